apb_master: RTL and testbench
=============================

# apb_master

APB3 bus master that connects the CPU-side load/store port to the peripheral bus. It converts a single-cycle CPU request into a compliant SETUP/ACCESS transfer and decodes the address into one of four slave selects. It multiplexes the slaves' PRDATA/PREADY back to the CPU and aborts transfers that stall too long. It sits directly upstream of GPIO, UART/FIFO and timer peripherals, each of which decodes only PADDR[3:0].

## Interface
- TIMEOUT, 16: maximum ACCESS cycles to wait for PREADY before aborting; must be at least 2.
- BASE, 32'h1000_0000: bus base address; slave i occupies BASE + i*32'h1000 .. + 32'hFFF.
- PCLK  in  1  clock
- PRESET  in  1  reset, asynchronous, active-high
- transfer  in  1  CPU request strobe; sampled only in IDLE
- write  in  1  1 = write, 0 = read; sampled with transfer
- addr  in  32  byte address; sampled with transfer
- wdata  in  32  write data; sampled with transfer
- rdata  out  32  read data; valid while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  valid with ready: unmapped address or timeout
- PADDR  out  32  latched addr
- PWDATA  out  32  latched wdata
- PWRITE  out  1  latched write
- PENABLE  out  1  APB enable
- PSEL  out  4  one-hot slave select
- PRDATA0..PRDATA3  in  32 each  slave read data
- PREADY0..PREADY3  in  1 each  slave ready

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - transfer=1 latches addr/wdata/write into PADDR/PWDATA/PWRITE.
  - Decode: mapped when addr[31:14] == BASE[31:14]. Slave index = addr[13:12].
  - Mapped -> SETUP. Unmapped -> stay IDLE; next cycle ready=1, err=1, rdata=0, PSEL never asserted.
- SETUP: PSEL[idx]=1, PENABLE=0. Unconditionally -> ACCESS. Wait counter cleared.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1.
  - Each cycle samples only the selected slave's PREADY; other slaves' PREADY are ignored.
  - PREADY=1: latch the selected PRDATA into rdata on reads (rdata=0 on writes), then -> IDLE. Next cycle ready=1, err=0.
  - PREADY=0: increment the wait counter. When the counter reaches TIMEOUT-1 with PREADY still 0, -> IDLE; next cycle ready=1, err=1, rdata=0.
- PADDR/PWDATA/PWRITE hold stable from SETUP through the end of ACCESS and keep their last value in IDLE.
- transfer outside IDLE is ignored; no queueing. The CPU waits for ready.
- A transfer asserted in the same cycle as ready (state IDLE) is accepted, giving back-to-back transfers.
- The wait counter is ceil(log2(TIMEOUT))+1 bits and saturates; it never wraps.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- PRESET mid-transfer: PSEL/PENABLE drop to 0 asynchronously. The transfer is lost and no ready is issued.
- Outputs are registered; no combinational path from slave inputs to CPU outputs.
- Mapped transfer latency, counted from the transfer-sampling edge e0:
  - SETUP in cycle 1, ACCESS from cycle 2.
  - Slave with zero wait states (PREADY high in cycle 2): ready in cycle 3.
  - Slave with registered PREADY (high in cycle 3): ready in cycle 4.
  - General rule: ready comes one cycle after the first ACCESS cycle with PREADY=1.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then ready/err follow one cycle later.
- Unmapped address: ready/err one cycle after e0.
- PSEL has at most one bit set, at any time.

## Test plan
- Reset: assert PRESET during ACCESS -> PSEL=0, PENABLE=0, ready=0 immediately; then IDLE.
- Write to 32'h1000_2008, wdata=32'hA5, slave 2 asserts PREADY one cycle into ACCESS:
  - PSEL=4'b0100 in cycles 1-3, PENABLE=1 in cycles 2-3, PWDATA=32'hA5, PADDR=32'h1000_2008 throughout.
  - ready=1, err=0 in cycle 4.
- Read of 32'h1000_0004, slave 0 returns PRDATA0=32'h0000_005A with zero-wait PREADY, while PREADY1=1 constantly:
  - ready in cycle 3, rdata=32'h5A.
  - PREADY1 has no effect on the transfer.
- Back-to-back: second transfer asserted in the ready cycle -> SETUP begins the next cycle with the new address.
- Unmapped read of 32'h2000_0000 -> PSEL stays 0; next cycle ready=1, err=1, rdata=0.
- Timeout with TIMEOUT=16, slave 3 never ready -> ACCESS held exactly 16 cycles, then ready=1, err=1, rdata=0. A following valid transfer completes normally.

Source files
------------

// File: rtl/apb_master_if.sv
// APB3 bus bundle between the master and its four slaves.
// Each slave has its own PRDATA/PREADY return path.
interface apb_master_if;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic [3:0]  PSEL;
  logic [31:0] PRDATA0;
  logic [31:0] PRDATA1;
  logic [31:0] PRDATA2;
  logic [31:0] PRDATA3;
  logic        PREADY0;
  logic        PREADY1;
  logic        PREADY2;
  logic        PREADY3;

  modport master (
    output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
    input  PREADY0, PREADY1, PREADY2, PREADY3
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
    output PREADY0, PREADY1, PREADY2, PREADY3
  );
endinterface

// File: rtl/apb_master.sv
// APB3 master: turns a one-cycle CPU request into a SETUP/ACCESS transfer
// to one of four decoded slaves, with a wait-state timeout abort.
module apb_master #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] BASE    = 32'h1000_0000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  apb_master_if.master apb
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         idx;
  logic [CNT_W-1:0]   cnt;
  logic               sel_ready;
  logic [31:0]        sel_rdata;
  logic               mapped;

  // Only the selected slave's return path is ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'h0;
    unique case (idx)
      2'd0: begin sel_ready = apb.PREADY0; sel_rdata = apb.PRDATA0; end
      2'd1: begin sel_ready = apb.PREADY1; sel_rdata = apb.PRDATA1; end
      2'd2: begin sel_ready = apb.PREADY2; sel_rdata = apb.PRDATA2; end
      default: begin sel_ready = apb.PREADY3; sel_rdata = apb.PRDATA3; end
    endcase
  end

  assign mapped = (addr[31:14] == BASE[31:14]);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      idx         <= 2'd0;
      cnt         <= '0;
      rdata       <= 32'h0;
      ready       <= 1'b0;
      err         <= 1'b0;
      apb.PADDR   <= 32'h0;
      apb.PWDATA  <= 32'h0;
      apb.PWRITE  <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PSEL    <= 4'b0000;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (transfer) begin
            apb.PADDR  <= addr;
            apb.PWDATA <= wdata;
            apb.PWRITE <= write;
            if (mapped) begin
              idx      <= addr[13:12];
              apb.PSEL <= 4'b0001 << addr[13:12];
              state    <= SETUP;
            end else begin
              // Unmapped: answer immediately with an error, bus stays quiet.
              ready <= 1'b1;
              err   <= 1'b1;
              rdata <= 32'h0;
            end
          end
        end

        SETUP: begin
          apb.PENABLE <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end

        ACCESS: begin
          if (sel_ready) begin
            rdata       <= apb.PWRITE ? 32'h0 : sel_rdata;
            ready       <= 1'b1;
            apb.PSEL    <= 4'b0000;
            apb.PENABLE <= 1'b0;
            state       <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // ACCESS has now lasted TIMEOUT cycles without PREADY.
            rdata       <= 32'h0;
            ready       <= 1'b1;
            err         <= 1'b1;
            apb.PSEL    <= 4'b0000;
            apb.PENABLE <= 1'b0;
            state       <= IDLE;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          apb.PSEL    <= 4'b0000;
          apb.PENABLE <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: the driver queues expected completions,
// a monitor pops and checks them whenever ready pulses.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  apb_master_if bus();

  apb_master #(.TIMEOUT(16), .BASE(32'h1000_0000)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .apb      (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;

  logic [31:0] rd_val [4];
  int          ws     [4];
  logic        force_rdy [4];
  int          acc = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  assign bus.PRDATA0 = rd_val[0];
  assign bus.PRDATA1 = rd_val[1];
  assign bus.PRDATA2 = rd_val[2];
  assign bus.PRDATA3 = rd_val[3];

  // Slave model: slave i raises PREADY on ACCESS cycle ws[i]+1 (ws=0 -> zero wait).
  always @(negedge PCLK) begin
    if (bus.PENABLE) acc = acc + 1;
    else             acc = 0;
    bus.PREADY0 = force_rdy[0] | (bus.PENABLE && bus.PSEL[0] && acc > ws[0]);
    bus.PREADY1 = force_rdy[1] | (bus.PENABLE && bus.PSEL[1] && acc > ws[1]);
    bus.PREADY2 = force_rdy[2] | (bus.PENABLE && bus.PSEL[2] && acc > ws[2]);
    bus.PREADY3 = force_rdy[3] | (bus.PENABLE && bus.PSEL[3] && acc > ws[3]);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge PCLK) begin
    if (!PRESET && ready === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_ready: got ready=1 want no completion (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("err", 32'(err), 32'(e.err));
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(negedge PCLK);
    #1;
  endtask

  // Issue one request; lat is the cycle (counted from the sampling edge) of ready.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input int lat);
    exp_t e;
    transfer = 1'b1;
    write    = w;
    addr     = a;
    wdata    = d;
    e.rdata  = er;
    e.err    = ee;
    e.cyc    = cyc + lat;
    q.push_back(e);
    step();
    transfer = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL completion_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int n_acc;
    PRESET   = 1'b1;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    for (int i = 0; i < 4; i++) begin
      rd_val[i]    = 32'h0;
      ws[i]        = 0;
      force_rdy[i] = 1'b0;
    end
    repeat (2) step();

    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_psel", 32'(bus.PSEL), 32'h0);
    chk("rst_penable", 32'(bus.PENABLE), 32'h0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_pwdata", bus.PWDATA, 32'h0);
    chk("rst_pwrite", 32'(bus.PWRITE), 32'h0);
    PRESET = 1'b0;
    step();

    // Write to slave 2 with one wait state: ready in cycle 4.
    ws[2] = 1;
    issue(1'b1, 32'h1000_2008, 32'h0000_00A5, 32'h0, 1'b0, 4);
    chk("wr_c1_psel", 32'(bus.PSEL), 32'h4);
    chk("wr_c1_penable", 32'(bus.PENABLE), 32'h0);
    chk("wr_c1_paddr", bus.PADDR, 32'h1000_2008);
    chk("wr_c1_pwdata", bus.PWDATA, 32'h0000_00A5);
    chk("wr_c1_pwrite", 32'(bus.PWRITE), 32'h1);
    step();
    chk("wr_c2_psel", 32'(bus.PSEL), 32'h4);
    chk("wr_c2_penable", 32'(bus.PENABLE), 32'h1);
    step();
    chk("wr_c3_psel", 32'(bus.PSEL), 32'h4);
    chk("wr_c3_penable", 32'(bus.PENABLE), 32'h1);
    chk("wr_c3_paddr", bus.PADDR, 32'h1000_2008);
    step();
    chk("wr_c4_psel", 32'(bus.PSEL), 32'h0);
    chk("wr_c4_paddr_hold", bus.PADDR, 32'h1000_2008);
    wait_done();

    // Zero-wait read of slave 0 while slave 1 holds PREADY high.
    ws[0] = 0; rd_val[0] = 32'h0000_005A;
    rd_val[1] = 32'hDEAD_BEEF; force_rdy[1] = 1'b1;
    issue(1'b0, 32'h1000_0004, 32'h0, 32'h0000_005A, 1'b0, 3);
    chk("rd0_c1_psel", 32'(bus.PSEL), 32'h1);
    wait_done();
    force_rdy[1] = 1'b0;
    step();

    // Back-to-back: second request issued in the ready cycle of the first.
    ws[1] = 0; rd_val[1] = 32'h1111_2222;
    ws[3] = 1; rd_val[3] = 32'h3333_4444;
    issue(1'b0, 32'h1000_1010, 32'h0, 32'h1111_2222, 1'b0, 3);
    step();
    step();
    issue(1'b0, 32'h1000_300C, 32'h0, 32'h3333_4444, 1'b0, 4);
    chk("b2b_setup_psel", 32'(bus.PSEL), 32'h8);
    chk("b2b_setup_paddr", bus.PADDR, 32'h1000_300C);
    chk("b2b_setup_penable", 32'(bus.PENABLE), 32'h0);
    wait_done();

    // Unmapped reads: far outside, and just past the four-slave window.
    issue(1'b0, 32'h2000_0000, 32'h0, 32'h0, 1'b1, 1);
    chk("unmap_psel", 32'(bus.PSEL), 32'h0);
    wait_done();
    issue(1'b0, 32'h1000_4000, 32'h0, 32'h0, 1'b1, 1);
    chk("unmap_edge_psel", 32'(bus.PSEL), 32'h0);
    wait_done();

    // Read from slave 2 with two wait states, after the earlier write.
    ws[2] = 2; rd_val[2] = 32'hCAFE_0002;
    issue(1'b0, 32'h1000_2FFC, 32'h0, 32'hCAFE_0002, 1'b0, 5);
    wait_done();

    // Timeout: slave 3 never ready, ACCESS lasts 16 cycles, ready in cycle 18.
    ws[3] = 1000;
    issue(1'b0, 32'h1000_3000, 32'h0, 32'h0, 1'b1, 18);
    n_acc = 0;
    for (int i = 0; i < 17; i++) begin
      step();
      if (bus.PENABLE === 1'b1) n_acc++;
    end
    chk("timeout_access_cycles", 32'(n_acc), 32'd16);
    wait_done();
    ws[3] = 0; rd_val[3] = 32'h0BAD_F00D;
    issue(1'b0, 32'h1000_3004, 32'h0, 32'h0BAD_F00D, 1'b0, 3);
    wait_done();

    // Reset in the middle of ACCESS: bus drops at once, no completion.
    ws[1] = 1000;
    issue(1'b1, 32'h1000_1000, 32'h1234_5678, 32'h0, 1'b0, 99);
    step();
    step();
    PRESET = 1'b1;
    #1;
    chk("rst_mid_psel", 32'(bus.PSEL), 32'h0);
    chk("rst_mid_penable", 32'(bus.PENABLE), 32'h0);
    chk("rst_mid_ready", 32'(ready), 32'h0);
    q.delete();
    step();
    PRESET = 1'b0;
    ws[1] = 0;
    repeat (3) step();
    chk("post_rst_psel", 32'(bus.PSEL), 32'h0);
    chk("post_rst_ready", 32'(ready), 32'h0);
    issue(1'b0, 32'h1000_1008, 32'h0, 32'h1111_2222, 1'b0, 3);
    wait_done();

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
